// File: rtl/nonce_sweep_pkg.sv
// Shared types and constants for the nonce sweep controller.
// Optional best-hash tracking: NONCE_SWEEP_BEST_TRACK_EN.
package nonce_sweep_pkg;

  localparam int LANES_DEF  = 16;
  localparam int LANE_W_DEF = 6;

  localparam logic [31:0] ALL_ONES     = 32'hFFFF_FFFF;
  localparam logic [31:0] BEST_H0_INIT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_SCAN,
    S_NEXT,
    S_FINISH
  } state_e;

endpackage

// File: rtl/nonce_sweep_ctrl_if.sv
// Hash core control/result bundle between sweep controller and core.
// master = controller side, slave = hash core side.
interface nonce_sweep_ctrl_if
  import nonce_sweep_pkg::*;
#(
  parameter int LANE_W = LANE_W_DEF
);

  logic              core_start;
  logic [31:0]       core_base_nonce;
  logic              core_done;
  logic [LANE_W-1:0] core_lane_sel;
  logic [31:0]       core_lane_h0;

  modport master (
    output core_start,
    output core_base_nonce,
    output core_lane_sel,
    input  core_done,
    input  core_lane_h0
  );

  modport slave (
    input  core_start,
    input  core_base_nonce,
    input  core_lane_sel,
    output core_done,
    output core_lane_h0
  );

endinterface

// File: rtl/nonce_range_calc.sv
// Range bookkeeping: lanes left in range, lane validity, last batch.
// Unsigned subtraction keeps the top-of-range case free of wrap.
module nonce_range_calc
  import nonce_sweep_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int LANE_W = LANE_W_DEF
) (
  input  logic [31:0]       cur_i,
  input  logic [31:0]       last_i,
  input  logic [LANE_W-1:0] lane_i,
  output logic              lane_valid_o,
  output logic              last_batch_o
);

  logic [31:0] remaining;

  assign remaining    = last_i - cur_i;
  assign lane_valid_o = 32'(lane_i) <= remaining;
  assign last_batch_o = remaining < 32'(LANES);

endmodule

// File: rtl/nonce_sweep_ctrl.sv
// Sweeps a multi-lane SHA-256 core over a nonce range, hunting H0 < target.
// Define NONCE_SWEEP_BEST_TRACK_EN to add best_h0/best_nonce tracking.
module nonce_sweep_ctrl
  import nonce_sweep_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int LANE_W = LANE_W_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_start,
  input  logic        cfg_abort,
  input  logic [31:0] nonce_first,
  input  logic [31:0] nonce_last,
  input  logic [31:0] target,
  nonce_sweep_ctrl_if.master core,
  output logic        busy,
  output logic        done,
  output logic        found,
  output logic [31:0] found_nonce,
  output logic [31:0] found_h0,
`ifdef NONCE_SWEEP_BEST_TRACK_EN
  output logic [31:0] best_h0,
  output logic [31:0] best_nonce,
`endif
  output logic [31:0] batch_cnt
);

  state_e            state_q, state_d;
  logic [31:0]       cur_q, cur_d;
  logic [31:0]       last_q, last_d;
  logic [31:0]       tgt_q, tgt_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic              busy_q, busy_d;
  logic              found_q, found_d;
  logic [31:0]       fn_q, fn_d;
  logic [31:0]       fh_q, fh_d;
  logic [31:0]       bcnt_q, bcnt_d;
`ifdef NONCE_SWEEP_BEST_TRACK_EN
  logic [31:0]       bh_q, bh_d;
  logic [31:0]       bn_q, bn_d;
`endif

  logic        lane_valid;
  logic        last_batch;
  logic        lane_last;
  logic        hit;
  logic [31:0] cand;

  nonce_range_calc #(
    .LANES (LANES),
    .LANE_W(LANE_W)
  ) u_range (
    .cur_i       (cur_q),
    .last_i      (last_q),
    .lane_i      (lane_q),
    .lane_valid_o(lane_valid),
    .last_batch_o(last_batch)
  );

  assign lane_last = lane_q == LANE_W'(LANES - 1);
  assign hit       = lane_valid && (core.core_lane_h0 < tgt_q);
  assign cand      = cur_q + 32'(lane_q);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    last_d  = last_q;
    tgt_d   = tgt_q;
    lane_d  = lane_q;
    busy_d  = busy_q;
    found_d = found_q;
    fn_d    = fn_q;
    fh_d    = fh_q;
    bcnt_d  = bcnt_q;
`ifdef NONCE_SWEEP_BEST_TRACK_EN
    bh_d    = bh_q;
    bn_d    = bn_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          cur_d   = nonce_first;
          last_d  = nonce_last;
          tgt_d   = target;
          busy_d  = 1'b1;
          found_d = 1'b0;
          fn_d    = '0;
          fh_d    = '0;
          bcnt_d  = '0;
`ifdef NONCE_SWEEP_BEST_TRACK_EN
          bh_d    = BEST_H0_INIT;
          bn_d    = '0;
`endif
          state_d = (nonce_first > nonce_last) ? S_FINISH : S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (core.core_done) begin
          if (bcnt_q != ALL_ONES) bcnt_d = bcnt_q + 32'd1;
          lane_d  = '0;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
`ifdef NONCE_SWEEP_BEST_TRACK_EN
        // Strict compare: on equal H0 the earlier nonce stays best.
        if (lane_valid && core.core_lane_h0 < bh_q) begin
          bh_d = core.core_lane_h0;
          bn_d = cand;
        end
        if (hit && !found_q) begin
          found_d = 1'b1;
          fn_d    = cand;
          fh_d    = core.core_lane_h0;
        end
        if (!lane_valid || lane_last || cfg_abort) state_d = S_NEXT;
        else lane_d = lane_q + 1'b1;
`else
        if (hit) begin
          found_d = 1'b1;
          fn_d    = cand;
          fh_d    = core.core_lane_h0;
          state_d = S_FINISH;
        end else if (!lane_valid || lane_last || cfg_abort) begin
          state_d = S_NEXT;
        end else begin
          lane_d = lane_q + 1'b1;
        end
`endif
      end
      S_NEXT: begin
`ifdef NONCE_SWEEP_BEST_TRACK_EN
        if (last_batch || cfg_abort || found_q) state_d = S_FINISH;
`else
        if (last_batch || cfg_abort) state_d = S_FINISH;
`endif
        else begin
          cur_d   = cur_q + 32'(LANES);
          state_d = S_ISSUE;
        end
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cur_q   <= '0;
      last_q  <= '0;
      tgt_q   <= '0;
      lane_q  <= '0;
      busy_q  <= 1'b0;
      found_q <= 1'b0;
      fn_q    <= '0;
      fh_q    <= '0;
      bcnt_q  <= '0;
`ifdef NONCE_SWEEP_BEST_TRACK_EN
      bh_q    <= '0;
      bn_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      tgt_q   <= tgt_d;
      lane_q  <= lane_d;
      busy_q  <= busy_d;
      found_q <= found_d;
      fn_q    <= fn_d;
      fh_q    <= fh_d;
      bcnt_q  <= bcnt_d;
`ifdef NONCE_SWEEP_BEST_TRACK_EN
      bh_q    <= bh_d;
      bn_q    <= bn_d;
`endif
    end
  end

  assign core.core_start      = state_q == S_ISSUE;
  assign core.core_base_nonce = cur_q;
  assign core.core_lane_sel   = lane_q;

  assign busy        = busy_q;
  assign done        = state_q == S_FINISH;
  assign found       = found_q;
  assign found_nonce = fn_q;
  assign found_h0    = fh_q;
  assign batch_cnt   = bcnt_q;
`ifdef NONCE_SWEEP_BEST_TRACK_EN
  assign best_h0     = bh_q;
  assign best_nonce  = bn_q;
`endif

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Bench for nonce_sweep_ctrl: range-level sweep model plus a hash core stub.
// Honours NONCE_SWEEP_BEST_TRACK_EN when defined.
module tb_nonce_sweep_ctrl;
  import nonce_sweep_pkg::*;

  localparam int L  = 16;
  localparam int LW = 6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_abort = 1'b0;
  logic [31:0] nonce_first = '0;
  logic [31:0] nonce_last = '0;
  logic [31:0] target = '0;
  logic        busy, done, found;
  logic [31:0] found_nonce, found_h0, batch_cnt;
`ifdef NONCE_SWEEP_BEST_TRACK_EN
  logic [31:0] best_h0, best_nonce;
`endif

  nonce_sweep_ctrl_if #(.LANE_W(LW)) core ();

  nonce_sweep_ctrl #(.LANES(L), .LANE_W(LW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cfg_start  (cfg_start),
    .cfg_abort  (cfg_abort),
    .nonce_first(nonce_first),
    .nonce_last (nonce_last),
    .target     (target),
    .core       (core),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .found_nonce(found_nonce),
    .found_h0   (found_h0),
`ifdef NONCE_SWEEP_BEST_TRACK_EN
    .best_h0    (best_h0),
    .best_nonce (best_nonce),
`endif
    .batch_cnt  (batch_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  // Core stub: explicit hits, otherwise large pseudo-random H0
  logic [31:0] hn[2];
  logic [31:0] hv[2];
  int          nh = 0;

  function automatic logic [31:0] h0_of(input logic [31:0] n);
    for (int i = 0; i < nh; i++)
      if (n == hn[i]) return hv[i];
    return 32'h1000_0000 + ((n * 32'h0000_9E37) & 32'h00FF_FFFF);
  endfunction

  logic [31:0] cbase = '0;
  int          t_cd = 0;

  initial begin
    core.core_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset_n && core.core_start) begin
        cbase = core.core_base_nonce;
        repeat (2) @(negedge clk);
        core.core_done = 1'b1;
        t_cd = cyc;
        @(negedge clk);
        core.core_done = 1'b0;
      end
    end
  end

  initial begin
    core.core_lane_h0 = '0;
    forever begin
      @(negedge clk);
      core.core_lane_h0 = h0_of(cbase + 32'(core.core_lane_sel));
    end
  end

  // Sweep model over the nonce range
  logic [31:0] exp_bases[$];
  logic        exp_found;
  logic [31:0] exp_fn, exp_fh, exp_bcnt, exp_bh, exp_bn;

  task automatic model(input logic [31:0] f, input logic [31:0] l,
                       input logic [31:0] t, input bit ab);
    longint b, nn, ll;
    bit stop;
    logic [31:0] h;
    exp_bases.delete();
    exp_found = 1'b0;
    exp_fn = '0;
    exp_fh = '0;
    exp_bcnt = '0;
    exp_bh = 32'hFFFF_FFFF;
    exp_bn = '0;
    if (f > l) return;
    b = longint'(f);
    ll = longint'(l);
    stop = 1'b0;
    while (!stop) begin
      exp_bases.push_back(b[31:0]);
      exp_bcnt++;
      for (int i = 0; i < L; i++) begin
        nn = b + i;
        if (nn > ll) break;
        h = h0_of(nn[31:0]);
        if (h < exp_bh) begin
          exp_bh = h;
          exp_bn = nn[31:0];
        end
        if (!exp_found && h < t) begin
          exp_found = 1'b1;
          exp_fn = nn[31:0];
          exp_fh = h;
        end
`ifndef NONCE_SWEEP_BEST_TRACK_EN
        if (exp_found) break;
`endif
      end
      if (exp_found || ab || (b + L > ll)) stop = 1'b1;
      else b = b + L;
    end
  endtask

  // Compare process
  bit          mon_en = 1'b0;
  int          idx = 0;
  int          ndone = 0;
  int          t_done = 0;
  logic [31:0] got_bases[$];

  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      if (core.core_start) begin
        got_bases.push_back(core.core_base_nonce);
        if (idx < exp_bases.size()) begin
          chk("core_base_nonce", core.core_base_nonce, exp_bases[idx]);
        end else begin
          tests++;
          fails++;
          $display("FAIL extra_core_start: got base 0x%08h, want none",
                   core.core_base_nonce);
        end
        idx++;
      end
      if (done) begin
        ndone++;
        t_done = cyc;
        chk("found", found, exp_found);
        chk("found_nonce", found_nonce, exp_fn);
        chk("found_h0", found_h0, exp_fh);
        chk("batch_cnt", batch_cnt, exp_bcnt);
        chk("n_core_start", idx, exp_bases.size());
        chk("busy_at_done", busy, 1);
`ifdef NONCE_SWEEP_BEST_TRACK_EN
        chk("best_h0", best_h0, exp_bh);
        chk("best_nonce", best_nonce, exp_bn);
`endif
      end
    end
  end

  function automatic logic [31:0] gb(input int i);
    if (i < got_bases.size()) return got_bases[i];
    return 32'hDEAD_DEAD;
  endfunction

  int t_start = 0;

  task automatic run(input logic [31:0] f, input logic [31:0] l,
                     input logic [31:0] t, input bit ab);
    int k;
    model(f, l, t, ab);
    idx = 0;
    ndone = 0;
    got_bases.delete();
    mon_en = 1'b1;
    @(negedge clk);
    nonce_first = f;
    nonce_last = l;
    target = t;
    cfg_start = 1'b1;
    t_start = cyc;
    @(negedge clk);
    cfg_start = 1'b0;
    if (ab) begin
      for (int j = 0; j < 50 && !core.core_start; j++) @(negedge clk);
      @(negedge clk);
      cfg_abort = 1'b1;
    end
    for (k = 0; k < 3000 && ndone == 0; k++) @(negedge clk);
    if (ndone == 0) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done, want done within 3000");
    end
    cfg_abort = 1'b0;
    @(negedge clk);
    chk("busy_after_done", busy, 0);
    chk("done_one_cycle", done, 0);
    mon_en = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_found"}, found, 0);
    chk({tag, "_found_nonce"}, found_nonce, 0);
    chk({tag, "_found_h0"}, found_h0, 0);
    chk({tag, "_batch_cnt"}, batch_cnt, 0);
    chk({tag, "_core_start"}, core.core_start, 0);
    chk({tag, "_core_base"}, core.core_base_nonce, 0);
    chk({tag, "_lane_sel"}, 32'(core.core_lane_sel), 0);
`ifdef NONCE_SWEEP_BEST_TRACK_EN
    chk({tag, "_best_h0"}, best_h0, 0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, want finish before 500000");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // three batches, never hits
    nh = 0;
    run(32'h100, 32'h12F, 32'h0, 1'b0);
    chk("t1_nbatches", got_bases.size(), 3);
    chk("t1_base0", gb(0), 32'h100);
    chk("t1_base1", gb(1), 32'h110);
    chk("t1_base2", gb(2), 32'h120);
    chk("t1_batch_cnt", batch_cnt, 3);
    chk("t1_found", found, 0);
    chk("t1_done_lat", 32'(t_done - t_cd), 18);

    // two hits, lower nonce wins
    nh = 2;
    hn[0] = 32'h13; hv[0] = 32'h5;
    hn[1] = 32'h17; hv[1] = 32'h3;
    run(32'h0, 32'h1F, 32'h10, 1'b0);
    chk("t2_found_nonce", found_nonce, 32'h13);
    chk("t2_found_h0", found_h0, 32'h5);
    chk("t2_batch_cnt", batch_cnt, 2);
`ifdef NONCE_SWEEP_BEST_TRACK_EN
    chk("t2_best_h0", best_h0, 32'h3);
    chk("t2_best_nonce", best_nonce, 32'h17);
`else
    chk("t2_done_lat", 32'(t_done - t_cd), 5);
`endif

    // top of the nonce space, hit on the last nonce
    nh = 1;
    hn[0] = 32'hFFFF_FFFF; hv[0] = 32'h42;
    run(32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'h100, 1'b0);
    chk("t3_found_nonce", found_nonce, 32'hFFFF_FFFF);
    chk("t3_found_h0", found_h0, 32'h42);
    chk("t3_nbatches", got_bases.size(), 1);
`ifdef NONCE_SWEEP_BEST_TRACK_EN
    chk("t3_done_lat", 32'(t_done - t_cd), 11);
`else
    chk("t3_done_lat", 32'(t_done - t_cd), 9);
`endif

    // same range, no hit: lane 8 must stop the scan
    nh = 0;
    run(32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'h100, 1'b0);
    chk("t3b_found", found, 0);
    chk("t3b_done_lat", 32'(t_done - t_cd), 11);

    // empty range
    run(32'h5, 32'h4, 32'h0, 1'b0);
    chk("t4_done_lat", 32'(t_done - t_start), 1);
    chk("t4_nbatches", got_bases.size(), 0);
    chk("t4_batch_cnt", batch_cnt, 0);

    // abort raised while the core runs batch 1
    run(32'h0, 32'hFF, 32'h0, 1'b1);
    chk("t5_batch_cnt", batch_cnt, 1);
    chk("t5_nbatches", got_bases.size(), 1);

    // reset in the middle of a scan
    @(negedge clk);
    nonce_first = 32'h0;
    nonce_last = 32'h3F;
    target = 32'h0;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int j = 0; j < 50 && !core.core_start; j++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("t6_busy_pre", busy, 1);
    chk("t6_bcnt_pre", batch_cnt, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("t6_rst");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    nh = 2;
    hn[0] = 32'h25; hv[0] = 32'h7;
    hn[1] = 32'h21; hv[1] = 32'h9;
    run(32'h20, 32'h3F, 32'h10, 1'b0);
    chk("t6_found_nonce", found_nonce, 32'h21);
    chk("t6_found_h0", found_h0, 32'h9);
    chk("t6_batch_cnt", batch_cnt, 1);
`ifdef NONCE_SWEEP_BEST_TRACK_EN
    chk("t6_best_h0", best_h0, 32'h7);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
